// File: rtl/tx_sched_flags.sv
// Per-flow ack/data/retransmit pending flags with a round-robin scanner that hands one request per flow to the TX engine.
// Command layout (MSB..LSB): {flowid[FLOWID_W], ack_sc[2], data_sc[2], rt_sc[2], timestamp[TS_W]}, sc: 0=NOP 1=SET 2=CLEAR.
module tx_sched_flags #(
    parameter int MAX_FLOWS = 8,
    parameter int FLOWID_W  = 3,
    parameter int TS_W      = 16,
    parameter int CMD_W     = FLOWID_W + 6 + TS_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_eng_tx_sched_cmd_val,
    input  logic [CMD_W-1:0]    rx_eng_tx_sched_cmd_data,
    output logic                tx_sched_rx_eng_cmd_rdy,
    input  logic                tx_timeout_tx_sched_cmd_val,
    input  logic [CMD_W-1:0]    tx_timeout_tx_sched_cmd_data,
    output logic                tx_sched_tx_timeout_cmd_rdy,
    output logic                tx_sched_tx_req_val,
    output logic [FLOWID_W-1:0] tx_sched_tx_req_flowid,
    output logic [2:0]          tx_sched_tx_req_flags,
    input  logic                tx_tx_sched_req_rdy
);
    localparam logic [1:0] SC_SET = 2'd1;
    localparam logic [1:0] SC_CLR = 2'd2;

    typedef enum logic {SCAN = 1'b0, ISSUE = 1'b1} state_t;

    state_t               state, state_nxt;
    logic [FLOWID_W-1:0]  scan_ptr, ptr_inc, cmd_flowid, req_flowid;
    logic [MAX_FLOWS-1:0] ack_pend, data_pend, rt_pend;
    logic [MAX_FLOWS-1:0] ack_nxt, data_nxt, rt_nxt;
    logic [CMD_W-1:0]     cmd;
    logic [1:0]           ack_sc, data_sc, rt_sc;
    logic [2:0]           cur_flags, req_flags;
    logic                 cmd_val, claim, advance;
    logic                 unused_ts;

    // RX engine always wins; the timeout engine waits whenever RX is presenting.
    assign tx_sched_rx_eng_cmd_rdy     = 1'b1;
    assign tx_sched_tx_timeout_cmd_rdy = ~rx_eng_tx_sched_cmd_val;

    assign cmd_val    = rx_eng_tx_sched_cmd_val | tx_timeout_tx_sched_cmd_val;
    assign cmd        = rx_eng_tx_sched_cmd_val ? rx_eng_tx_sched_cmd_data : tx_timeout_tx_sched_cmd_data;
    assign cmd_flowid = cmd[CMD_W-1 -: FLOWID_W];
    assign ack_sc     = cmd[TS_W+5 -: 2];
    assign data_sc    = cmd[TS_W+3 -: 2];
    assign rt_sc      = cmd[TS_W+1 -: 2];
    assign unused_ts  = ^cmd[TS_W-1:0];

    function automatic logic sc_apply(input logic [1:0] sc, input logic cur);
        case (sc)
            SC_SET:  return 1'b1;
            SC_CLR:  return 1'b0;
            default: return cur;
        endcase
    endfunction

    always_comb begin
        cur_flags = '0;
        for (int f = 0; f < MAX_FLOWS; f++)
            if (scan_ptr == FLOWID_W'(f))
                cur_flags = {rt_pend[f], data_pend[f], ack_pend[f]};
    end

    assign claim   = (state == SCAN) && (|cur_flags);
    assign advance = ((state == SCAN) && !claim) || ((state == ISSUE) && tx_tx_sched_req_rdy);
    assign ptr_inc = (scan_ptr == FLOWID_W'(MAX_FLOWS - 1)) ? '0 : scan_ptr + FLOWID_W'(1);

    // Claim clears first, then the command is layered on top so a same-cycle SET survives.
    // Out-of-range flow ids match no entry and are dropped.
    always_comb begin
        ack_nxt  = ack_pend;
        data_nxt = data_pend;
        rt_nxt   = rt_pend;
        for (int f = 0; f < MAX_FLOWS; f++) begin
            if (claim && scan_ptr == FLOWID_W'(f)) begin
                ack_nxt[f]  = 1'b0;
                data_nxt[f] = 1'b0;
                rt_nxt[f]   = 1'b0;
            end
            if (cmd_val && cmd_flowid == FLOWID_W'(f)) begin
                ack_nxt[f]  = sc_apply(ack_sc, ack_nxt[f]);
                data_nxt[f] = sc_apply(data_sc, data_nxt[f]);
                rt_nxt[f]   = sc_apply(rt_sc, rt_nxt[f]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= SCAN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:    if (claim) state_nxt = ISSUE;
            ISSUE:   if (tx_tx_sched_req_rdy) state_nxt = SCAN;
            default: state_nxt = SCAN;
        endcase
    end

    always_comb begin
        tx_sched_tx_req_val = (state == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_pend   <= '0;
            data_pend  <= '0;
            rt_pend    <= '0;
            scan_ptr   <= '0;
            req_flowid <= '0;
            req_flags  <= '0;
        end else begin
            ack_pend  <= ack_nxt;
            data_pend <= data_nxt;
            rt_pend   <= rt_nxt;
            if (advance) scan_ptr <= ptr_inc;
            if (claim) begin
                req_flowid <= scan_ptr;
                req_flags  <= cur_flags;
            end
        end
    end

    assign tx_sched_tx_req_flowid = req_flowid;
    assign tx_sched_tx_req_flags  = req_flags;
endmodule

// File: doc/tx_sched_flags.md
Name: tx_sched_flags

Overview:
- Downstream consumer of the per-flow retransmit-timeout scanner and of the RX engine's ack/data events.
- Holds three pending flags per TCP flow: ack_pend, data_pend and rt_pend.
- Applies sched_cmd_struct set/clear commands from two sources.
- Round-robin scans flows with any flag set and issues one transmit request per flow to the TX engine, using a val/rdy handshake.

Parameters:
- MAX_FLOWS, default MAX_TCP_FLOWS: number of tracked flows; power of 2 not required.
- FLOWID_W, default FLOWID_W (tcp_pkg): flow id width; must satisfy 2^FLOWID_W >= MAX_FLOWS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rx_eng_tx_sched_cmd_val  in  1  RX-engine command valid
- rx_eng_tx_sched_cmd_data  in  sched_cmd_struct  RX-engine command
- tx_sched_rx_eng_cmd_rdy  out  1  RX-engine command ready
- tx_timeout_tx_sched_cmd_val  in  1  timeout-engine command valid
- tx_timeout_tx_sched_cmd_data  in  sched_cmd_struct  timeout-engine command
- tx_sched_tx_timeout_cmd_rdy  out  1  timeout-engine command ready
- tx_sched_tx_req_val  out  1  transmit request valid
- tx_sched_tx_req_flowid  out  FLOWID_W  flow to service
- tx_sched_tx_req_flags  out  3  {rt_pend, data_pend, ack_pend} snapshot
- tx_tx_sched_req_rdy  in  1  TX engine accepts request

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset state:
  - all flags 0; scan_ptr 0; FSM in SCAN.
  - tx_sched_tx_req_val 0; flowid 0; flags 0.
  - both command rdy outputs follow their combinational rules; tx_sched_rx_eng_cmd_rdy is always 1.
- Command arbitration:
  - RX engine has fixed priority; tx_sched_rx_eng_cmd_rdy = 1 always.
  - tx_sched_tx_timeout_cmd_rdy = ~rx_eng_tx_sched_cmd_val.
  - At most one command is applied per cycle.
- Command apply (on val & rdy): for each of ack/data/rt_pend_set_clear, SET sets the flag at cmd.flowid, CLEAR clears it, NOP leaves it unchanged.
  - .timestamp fields are ignored.
  - The new flag value is visible to the scanner on the next cycle.
  - flowid >= MAX_FLOWS: command is accepted and discarded.
- FSM states:
  - SCAN: if any flag at scan_ptr is set, latch req_flowid = scan_ptr and req_flags = the three flags, clear those flags, go to ISSUE. Otherwise scan_ptr increments and FSM stays in SCAN.
  - ISSUE: tx_sched_tx_req_val = 1; flowid and flags are held stable. On tx_tx_sched_req_rdy: scan_ptr increments, go to SCAN. Val is low the following cycle.
- scan_ptr increment wraps from MAX_FLOWS-1 to 0.
- One flow is inspected per SCAN cycle.
- Worst-case latency from a flag being applied to the request being issued: MAX_FLOWS+1 cycles when the TX engine is idle.
- Boundary: same-cycle claim and SET on the same flow and field → the SET wins and the flag stays set.
  - The snapshot still carries the bit.
  - The flow is reissued on the next visit.
- Boundary: same-cycle claim and CLEAR → the flag ends 0; the snapshot is unaffected and the request still issues.
- Boundary: commands during ISSUE are applied normally, including to the flow being issued; the held request does not change.
- Boundary: all flows pending → strict round-robin; each flow is issued once per lap.
- Reset mid-ISSUE: val drops on the cycle after rst, and all pending flags are lost.

Test Plan:
- rt SET for flowid 3 from timeout port, tx rdy=1 → one request: flowid 3, flags 3'b100; rt_pend[3]=0 afterward; no further requests.
- Same cycle: RX cmd ack SET flowid 1 and timeout cmd rt SET flowid 1.
  - Expected: timeout rdy=0 that cycle; timeout cmd applied the next cycle.
  - Expected: the final request(s) for flowid 1 cover both ack and rt.
- Data SET for flows 0, 2, 5 (MAX_FLOWS=8), rdy=1 → requests issued in order 0, 2, 5.
  - Then data SET for flow 1 while ptr=6 → flow 1 issued after wrap via 7→0→1.
- Hold tx rdy=0 for 10 cycles with a request for flow 4 pending, then send a CLEAR of data on flow 4 → val, flowid and flags stay stable; request completes when rdy=1.
- SET ack on flow 2 in the exact cycle the scanner claims flow 2 → flow 2 issued twice, the second time with flags 3'b001.
- Assert rst during ISSUE with 3 flags pending → val=0 next cycle; no requests afterward without new commands.
